// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg
//   Shared definitions for the SR latch driver: FSM state encoding and the
//   width of the shared pulse/guard down-counter.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// sync2
//   Two-flop synchronizer bringing the asynchronous latch Q readback into
//   the clk domain. Both flops clear to 0 on synchronous reset.
// Ports
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous, active-low reset
//   d      in  1  asynchronous input
//   q      out 1  synchronized output, two cycles of latency
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Converts one-cycle set/reset requests into registered, width-controlled
//   low pulses on the active-low Sbar/Rbar inputs of a NAND SR latch, never
//   driving both low, then reads the latch Q back to confirm the write.
// Parameters
//   PULSE_W  cycles the selected bar is held low (1..255)
//   GAP_W    guard cycles after a pulse before the next request (>= 3)
// Ports
//   clk       in  1  rising-edge clock
//   rst_n     in  1  synchronous, active-low reset
//   set_req   in  1  set request, sampled while req_ready=1
//   rst_req   in  1  reset request, sampled while req_ready=1 (wins over set)
//   req_ready out 1  driver idle, a request this cycle is accepted
//   sbar      out 1  latch Sbar, active low, registered
//   rbar      out 1  latch Rbar, active low, registered
//   q_fb      in  1  latch Q readback, asynchronous
//   busy      out 1  inverse of req_ready
//   collide   out 1  one-cycle pulse: set and reset accepted together
//   err       out 1  one-cycle pulse: readback disagreed with written value
import sr_drv_pkg::*;

module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  output logic req_ready,
  output logic sbar,
  output logic rbar,
  input  logic q_fb,
  output logic busy,
  output logic collide,
  output logic err
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             exp_q, exp_nx;
  logic             ready_q;
  logic             accept;
  logic             sbar_nx, rbar_nx;
  logic             collide_nx, err_nx;
  logic             q_sync;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_fb),
    .q     (q_sync)
  );

  // ready_q is registered so it reads 0 throughout reset and 1 only from
  // the first edge after release; it is 1 exactly when the FSM is in IDLE.
  assign accept    = ready_q & (set_req | rst_req);
  assign req_ready = ready_q;
  assign busy      = ~ready_q;

  // Next-state, counter and pulse-flag logic. The bars are derived from the
  // next state so they are registered yet change on the accepting edge.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    exp_nx     = exp_q;
    collide_nx = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx   = PULSE;
          cnt_nx     = PULSE_LOAD;
          exp_nx     = ~rst_req;
          collide_nx = set_req & rst_req;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nx = GUARD;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      GUARD: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          err_nx   = (q_sync != exp_q);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // Only one bar can be selected by exp_nx, so both-low is impossible.
    sbar_nx = ~((state_nx == PULSE) &  exp_nx);
    rbar_nx = ~((state_nx == PULSE) & ~exp_nx);
  end

  // State and output registers; reset releases both bars on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      exp_q   <= 1'b0;
      ready_q <= 1'b0;
      sbar    <= 1'b1;
      rbar    <= 1'b1;
      collide <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      exp_q   <= exp_nx;
      ready_q <= (state_nx == IDLE);
      sbar    <= sbar_nx;
      rbar    <= rbar_nx;
      collide <= collide_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver
//   Drives sr_latch_driver at default parameters with a behavioural NAND SR
//   latch on sbar/rbar feeding q_fb, using a table of write transactions and
//   hand-written sequences for reset and stuck-latch corner cases.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic rst_req = 1'b0;
  logic q_fb;
  logic req_ready, sbar, rbar, busy, collide, err;

  logic latch_q = 1'b0;
  logic stuck = 1'b0;
  logic armed = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic s;
    logic r;
    logic inj;
    logic stk;
    logic expq;
    logic expcoll;
    logic experr;
  } vec_t;

  vec_t vecs[10];

  sr_latch_driver #(.PULSE_W(4), .GAP_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_req   (set_req),
    .rst_req   (rst_req),
    .req_ready (req_ready),
    .sbar      (sbar),
    .rbar      (rbar),
    .q_fb      (q_fb),
    .busy      (busy),
    .collide   (collide),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Cross-coupled NAND latch behaviour: low Sbar sets, low Rbar clears.
  always @(sbar, rbar) begin
    if (!sbar && rbar) latch_q = 1'b1;
    else if (sbar && !rbar) latch_q = 1'b0;
    else if (!sbar && !rbar) latch_q = 1'b1;
  end

  assign q_fb = stuck ? 1'b0 : latch_q;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // The two bars must never be low together, checked every cycle.
  always @(negedge clk) begin
    if (armed) checkOutput("never_both_low", {7'd0, sbar | rbar}, 8'd1);
  end

  // One write transaction starting at a negedge with the driver idle; ends
  // at the negedge of the cycle where req_ready should have returned.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] selv, othv, rdyv, errv, colv;
    stuck = v.stk;
    checkOutput($sformatf("vec%0d.ready_before", idx), {7'd0, req_ready}, 8'd1);
    checkOutput($sformatf("vec%0d.busy_before", idx), {7'd0, busy}, 8'd0);
    set_req = v.s;
    rst_req = v.r;
    @(negedge clk);
    set_req = 1'b0;
    rst_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      selv[k] = v.expq ? sbar : rbar;
      othv[k] = v.expq ? rbar : sbar;
      rdyv[k] = req_ready;
      errv[k] = err;
      colv[k] = collide;
      if (v.inj && k == 1) rst_req = 1'b1;
      else if (v.inj && k == 2) rst_req = 1'b0;
    end
    checkOutput($sformatf("vec%0d.sel_bar", idx), selv, 8'hF0);
    checkOutput($sformatf("vec%0d.other_bar", idx), othv, 8'hFF);
    checkOutput($sformatf("vec%0d.ready", idx), rdyv, 8'h80);
    checkOutput($sformatf("vec%0d.err", idx), errv, v.experr ? 8'h80 : 8'h00);
    checkOutput($sformatf("vec%0d.collide", idx), colv, v.expcoll ? 8'h01 : 8'h00);
    checkOutput($sformatf("vec%0d.latch_q", idx), {7'd0, latch_q}, {7'd0, v.expq});
    stuck = 1'b0;
  endtask

  initial begin
    logic errAcc;
    //             s     r     inj   stk   expq  coll  err
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held for three edges, then released.
    rst_n = 1'b0;
    @(negedge clk);
    armed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.sbar", {7'd0, sbar}, 8'd1);
    checkOutput("reset.rbar", {7'd0, rbar}, 8'd1);
    checkOutput("reset.err", {7'd0, err}, 8'd0);
    checkOutput("reset.collide", {7'd0, collide}, 8'd0);
    checkOutput("reset.ready", {7'd0, req_ready}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset.ready_after", {7'd0, req_ready}, 8'd1);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Reset asserted during the second cycle of a set pulse.
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    checkOutput("midrst.sbar_low", {7'd0, sbar}, 8'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst.sbar", {7'd0, sbar}, 8'd1);
    checkOutput("midrst.rbar", {7'd0, rbar}, 8'd1);
    checkOutput("midrst.ready", {7'd0, req_ready}, 8'd0);
    checkOutput("midrst.err", {7'd0, err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst.ready_after", {7'd0, req_ready}, 8'd1);
    errAcc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      errAcc = errAcc | err | ~sbar | ~rbar;
      @(negedge clk);
    end
    checkOutput("midrst.quiet", {7'd0, errAcc}, 8'd0);
    applyStimulus(vecs[2], 10);

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
